// File: rtl/fei4_cmd_pkg.sv
// Command-link constants and types shared by the FE-I4 command decoder and the sequencer bench.
// Holds header/field codes, RunMode patterns, the FSM state enum and the strobe bundle.
package fei4_cmd_pkg;

   localparam logic [4:0] CMD_LV1    = 5'b11101;
   localparam logic [4:0] CMD_FIELD1 = 5'b10110;

   localparam logic [3:0] F2_BCR     = 4'b0001;
   localparam logic [3:0] F2_ECR     = 4'b0010;
   localparam logic [3:0] F2_CAL     = 4'b0100;
   localparam logic [3:0] F2_FIELD2  = 4'b1000;

   localparam logic [3:0] F3_RD_REG  = 4'b0001;
   localparam logic [3:0] F3_WR_REG  = 4'b0010;
   localparam logic [3:0] F3_WR_FE   = 4'b0100;
   localparam logic [3:0] F3_GRST    = 4'b1000;
   localparam logic [3:0] F3_GPULSE  = 4'b1001;
   localparam logic [3:0] F3_RUNMODE = 4'b1010;

   localparam logic [5:0] RUNMODE_RUN  = 6'b111000;
   localparam logic [5:0] RUNMODE_CONF = 6'b000111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_F2,
      ST_F3,
      ST_CHIPID,
      ST_F5,
      ST_DATA,
      ST_FEDATA
   } state_t;

   typedef struct packed {
      logic lv1;
      logic bcr;
      logic ecr;
      logic cal;
      logic grst;
      logic gp_ld;
      logic run_set;
      logic run_clr;
      logic reg_rd;
      logic reg_wr;
      logic fe_vld;
      logic fe_dat;
      logic fe_done;
      logic err;
   } strb_t;

   function automatic logic chip_selected(input logic [3:0] id, input logic [2:0] chip);
      return id[3] | (id[2:0] == chip);
   endfunction

   function automatic logic f3_legal(input logic [3:0] code);
      return (code == F3_RD_REG) || (code == F3_WR_REG) || (code == F3_WR_FE) ||
             (code == F3_GRST) || (code == F3_GPULSE) || (code == F3_RUNMODE);
   endfunction

endpackage

// File: rtl/fei4_cmd_decoder_if.sv
// Serial command input plus every decoded output of the FE-I4 command decoder.
// master = command sequencer side, slave = decoder side.
interface fei4_cmd_decoder_if;
   logic        CMD_DATA;
   logic        LV1;
   logic        BCR;
   logic        ECR;
   logic        CAL;
   logic        GRST;
   logic        GPULSE;
   logic        RUN_MODE;
   logic        REG_RD;
   logic        REG_WR;
   logic [5:0]  REG_ADDR;
   logic [15:0] REG_DATA;
   logic        FE_SR_DATA;
   logic        FE_SR_VALID;
   logic        FE_SR_DONE;
   logic        CMD_ERR;
   logic        BUSY;

   modport master (
      output CMD_DATA,
      input  LV1, BCR, ECR, CAL, GRST, GPULSE, RUN_MODE, REG_RD, REG_WR,
             REG_ADDR, REG_DATA, FE_SR_DATA, FE_SR_VALID, FE_SR_DONE, CMD_ERR, BUSY
   );

   modport slave (
      input  CMD_DATA,
      output LV1, BCR, ECR, CAL, GRST, GPULSE, RUN_MODE, REG_RD, REG_WR,
             REG_ADDR, REG_DATA, FE_SR_DATA, FE_SR_VALID, FE_SR_DONE, CMD_ERR, BUSY
   );
endinterface

// File: rtl/fei4_cmd_decoder.sv
// FE-I4 command-link responder: deserialises CMD_DATA and decodes trigger/fast/slow commands.
// Strobes appear one edge after the edge sampling a command's last bit; the link has no backpressure.
module fei4_cmd_decoder
   import fei4_cmd_pkg::*;
#(
   parameter logic [2:0] CHIP_ID   = 3'b000,
   parameter int         FE_SR_LEN = 672
) (
   input  logic               CMD_CLK,
   input  logic               RST,
   fei4_cmd_decoder_if.slave  bus
);

   state_t      state, state_d;
   logic [10:0] cnt, cnt_d;
   logic [14:0] sr;
   logic [3:0]  code, code_d;
   logic        sel, sel_d;
   logic [5:0]  addr, addr_d;
   logic        busy_q;

   strb_t       s1, s1_d;
   logic [5:0]  s1_addr, s1_addr_d;
   logic [15:0] s1_data, s1_data_d;
   logic [5:0]  s1_width, s1_width_d;

   logic        lv1_q, bcr_q, ecr_q, cal_q, grst_q, run_q, rd_q, wr_q;
   logic        fe_dat_q, fe_vld_q, fe_done_q, err_q;
   logic [5:0]  reg_addr_q;
   logic [15:0] reg_data_q;
   logic [5:0]  pulse_cnt;

   logic        din;
   logic        last;
   logic [3:0]  field4;
   logic [4:0]  field5;
   logic [5:0]  field6;
   logic [15:0] field16;

   // The shift register holds the previous 15 bits; the live input is the newest field bit.
   assign din     = bus.CMD_DATA;
   assign last    = (cnt == 11'd0);
   assign field4  = {sr[2:0], din};
   assign field5  = {sr[3:0], din};
   assign field6  = {sr[4:0], din};
   assign field16 = {sr, din};

   always_ff @(posedge CMD_CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         sr       <= '0;
         code     <= '0;
         sel      <= 1'b0;
         addr     <= '0;
         busy_q   <= 1'b0;
         s1       <= '0;
         s1_addr  <= '0;
         s1_data  <= '0;
         s1_width <= '0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         sr       <= field16[14:0];
         code     <= code_d;
         sel      <= sel_d;
         addr     <= addr_d;
         busy_q   <= (state != ST_IDLE) || din;
         s1       <= s1_d;
         s1_addr  <= s1_addr_d;
         s1_data  <= s1_data_d;
         s1_width <= s1_width_d;
      end
   end

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      code_d     = code;
      sel_d      = sel;
      addr_d     = addr;
      s1_d       = '0;
      s1_addr_d  = s1_addr;
      s1_data_d  = s1_data;
      s1_width_d = s1_width;

      if (state != ST_IDLE && !last)
         cnt_d = cnt - 11'd1;

      case (state)
         ST_IDLE: begin
            if (din) begin
               state_d = ST_HDR;
               cnt_d   = 11'd3;
            end
         end
         ST_HDR: begin
            if (last) begin
               if (field5 == CMD_LV1) begin
                  s1_d.lv1 = 1'b1;
                  state_d  = ST_IDLE;
               end else if (field5 == CMD_FIELD1) begin
                  state_d = ST_F2;
                  cnt_d   = 11'd3;
               end else begin
                  s1_d.err = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         ST_F2: begin
            if (last) begin
               state_d = ST_IDLE;
               case (field4)
                  F2_BCR:    s1_d.bcr = 1'b1;
                  F2_ECR:    s1_d.ecr = 1'b1;
                  F2_CAL:    s1_d.cal = 1'b1;
                  F2_FIELD2: begin
                     state_d = ST_F3;
                     cnt_d   = 11'd3;
                  end
                  default:   s1_d.err = 1'b1;
               endcase
            end
         end
         ST_F3: begin
            if (last) begin
               code_d = field4;
               if (f3_legal(field4)) begin
                  state_d = ST_CHIPID;
                  cnt_d   = 11'd3;
               end else begin
                  s1_d.err = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         ST_CHIPID: begin
            if (last) begin
               sel_d   = chip_selected(field4, CHIP_ID);
               state_d = ST_F5;
               cnt_d   = 11'd5;
            end
         end
         ST_F5: begin
            if (last) begin
               state_d = ST_IDLE;
               case (code)
                  F3_RD_REG: begin
                     s1_d.reg_rd = sel;
                     if (sel) s1_addr_d = field6;
                  end
                  F3_WR_REG: begin
                     addr_d  = field6;
                     state_d = ST_DATA;
                     cnt_d   = 11'd15;
                  end
                  F3_WR_FE: begin
                     state_d = ST_FEDATA;
                     cnt_d   = 11'(FE_SR_LEN - 1);
                  end
                  F3_GRST:   s1_d.grst = sel;
                  F3_GPULSE: begin
                     s1_d.gp_ld = sel;
                     if (sel) s1_width_d = field6;
                  end
                  F3_RUNMODE: begin
                     // Unselected chips swallow even a malformed pattern silently.
                     if (sel) begin
                        if (field6 == RUNMODE_RUN)       s1_d.run_set = 1'b1;
                        else if (field6 == RUNMODE_CONF) s1_d.run_clr = 1'b1;
                        else                             s1_d.err     = 1'b1;
                     end
                  end
                  default: s1_d.err = 1'b1;
               endcase
            end
         end
         ST_DATA: begin
            if (last) begin
               state_d     = ST_IDLE;
               s1_d.reg_wr = sel;
               if (sel) begin
                  s1_addr_d = addr;
                  s1_data_d = field16;
               end
            end
         end
         ST_FEDATA: begin
            s1_d.fe_vld  = sel;
            s1_d.fe_dat  = sel & din;
            s1_d.fe_done = sel & last;
            if (last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CMD_CLK) begin
      if (RST) begin
         lv1_q      <= 1'b0;
         bcr_q      <= 1'b0;
         ecr_q      <= 1'b0;
         cal_q      <= 1'b0;
         grst_q     <= 1'b0;
         run_q      <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         fe_dat_q   <= 1'b0;
         fe_vld_q   <= 1'b0;
         fe_done_q  <= 1'b0;
         err_q      <= 1'b0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         pulse_cnt  <= '0;
      end else begin
         lv1_q     <= s1.lv1;
         bcr_q     <= s1.bcr;
         ecr_q     <= s1.ecr;
         cal_q     <= s1.cal;
         grst_q    <= s1.grst;
         rd_q      <= s1.reg_rd;
         wr_q      <= s1.reg_wr;
         fe_dat_q  <= s1.fe_dat;
         fe_vld_q  <= s1.fe_vld;
         fe_done_q <= s1.fe_done;
         err_q     <= s1.err;
         if (s1.reg_rd || s1.reg_wr) reg_addr_q <= s1_addr;
         if (s1.reg_wr)              reg_data_q <= s1_data;
         if (s1.run_set)      run_q <= 1'b1;
         else if (s1.run_clr) run_q <= 1'b0;
         // A zero width still yields a one-cycle pulse; a reload restarts the count.
         if (s1.gp_ld)
            pulse_cnt <= (s1_width == 6'd0) ? 6'd1 : s1_width;
         else if (pulse_cnt != 6'd0)
            pulse_cnt <= pulse_cnt - 6'd1;
      end
   end

   assign bus.LV1         = lv1_q;
   assign bus.BCR         = bcr_q;
   assign bus.ECR         = ecr_q;
   assign bus.CAL         = cal_q;
   assign bus.GRST        = grst_q;
   assign bus.GPULSE      = (pulse_cnt != 6'd0);
   assign bus.RUN_MODE    = run_q;
   assign bus.REG_RD      = rd_q;
   assign bus.REG_WR      = wr_q;
   assign bus.REG_ADDR    = reg_addr_q;
   assign bus.REG_DATA    = reg_data_q;
   assign bus.FE_SR_DATA  = fe_dat_q;
   assign bus.FE_SR_VALID = fe_vld_q;
   assign bus.FE_SR_DONE  = fe_done_q;
   assign bus.CMD_ERR     = err_q;
   assign bus.BUSY        = busy_q;

endmodule

// File: tb/tb_fei4_cmd_decoder.sv
// Directed bench for fei4_cmd_decoder: serial command vectors with hand-computed strobe counts and timing.
module tb_fei4_cmd_decoder;
   import fei4_cmd_pkg::*;

   logic CMD_CLK = 1'b0;
   logic RST     = 1'b1;

   fei4_cmd_decoder_if bus();

   fei4_cmd_decoder #(.CHIP_ID(3'b000), .FE_SR_LEN(672)) dut (
      .CMD_CLK (CMD_CLK),
      .RST     (RST),
      .bus     (bus)
   );

   always #5 CMD_CLK = ~CMD_CLK;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;

   int n_lv1, n_bcr, n_ecr, n_cal, n_grst, n_rd, n_wr, n_err;
   int n_gp, n_busy, n_fev, n_fedone, fe_bad, fe_done_at;
   int lv1_cyc, ecr_cyc, wr_cyc, err_cyc, gp_first, fe_first;
   int rec_addr, rec_data;

   always @(posedge CMD_CLK) cyc <= cyc + 1;

   always @(negedge CMD_CLK) begin
      if (bus.LV1)     begin n_lv1++; lv1_cyc = cyc; end
      if (bus.BCR)     n_bcr++;
      if (bus.ECR)     begin n_ecr++; ecr_cyc = cyc; end
      if (bus.CAL)     n_cal++;
      if (bus.GRST)    n_grst++;
      if (bus.REG_RD)  begin n_rd++; rec_addr = int'(bus.REG_ADDR); end
      if (bus.REG_WR)  begin
         n_wr++; wr_cyc = cyc;
         rec_addr = int'(bus.REG_ADDR);
         rec_data = int'(bus.REG_DATA);
      end
      if (bus.CMD_ERR) begin n_err++; err_cyc = cyc; end
      if (bus.GPULSE)  begin n_gp++; if (gp_first < 0) gp_first = cyc; end
      if (bus.BUSY)    n_busy++;
      if (bus.FE_SR_VALID) begin
         if (n_fev == 0) fe_first = cyc;
         if (bus.FE_SR_DATA !== ((n_fev % 2) == 0)) fe_bad++;
         n_fev++;
      end
      if (bus.FE_SR_DONE) begin n_fedone++; fe_done_at = n_fev; end
   end

   task automatic clear_counts();
      n_lv1 = 0; n_bcr = 0; n_ecr = 0; n_cal = 0; n_grst = 0; n_rd = 0; n_wr = 0; n_err = 0;
      n_gp = 0; n_busy = 0; n_fev = 0; n_fedone = 0; fe_bad = 0; fe_done_at = -1;
      lv1_cyc = -1; ecr_cyc = -1; wr_cyc = -1; err_cyc = -1; gp_first = -1; fe_first = -1;
      rec_addr = -1; rec_data = -1;
   endtask

   task automatic send(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge CMD_CLK);
         if (i == n - 1) t0 = cyc + 1;
         bus.CMD_DATA = v[i];
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CMD_CLK);
         bus.CMD_DATA = 1'b0;
      end
   endtask

   function automatic logic [22:0] slow(input logic [3:0] c, input logic [3:0] chip, input logic [5:0] f5);
      return {CMD_FIELD1, F2_FIELD2, c, chip, f5};
   endfunction

   function automatic logic [35:0] all_outs();
      return {bus.LV1, bus.BCR, bus.ECR, bus.CAL, bus.GRST, bus.GPULSE, bus.RUN_MODE,
              bus.REG_RD, bus.REG_WR, bus.REG_ADDR, bus.REG_DATA, bus.FE_SR_DATA,
              bus.FE_SR_VALID, bus.FE_SR_DONE, bus.CMD_ERR, bus.BUSY};
   endfunction

   task automatic test_reset();
      RST = 1'b1;
      bus.CMD_DATA = 1'b0;
      repeat (3) @(negedge CMD_CLK);
      total++;
      if (all_outs() !== 36'd0) begin bad++; $display("FAIL reset_outs got=%h want=0", all_outs()); end
      RST = 1'b0;
      clear_counts();
      idle(8);
      total++;
      if (n_busy !== 0) begin bad++; $display("FAIL idle_zeros_busy got=%0d want=0", n_busy); end
      total++;
      if (all_outs() !== 36'd0) begin bad++; $display("FAIL idle_outs got=%h want=0", all_outs()); end
   endtask

   task automatic test_lv1();
      clear_counts();
      send(64'(5'b11101), 5);
      idle(10);
      total++;
      if (n_lv1 !== 1) begin bad++; $display("FAIL lv1_count got=%0d want=1", n_lv1); end
      total++;
      if (lv1_cyc !== t0 + 5) begin bad++; $display("FAIL lv1_latency got=%0d want=%0d", lv1_cyc, t0 + 5); end
      total++;
      if (n_bcr + n_ecr + n_cal + n_grst + n_rd + n_wr + n_err + n_gp !== 0) begin
         bad++; $display("FAIL lv1_other_strobes got=%0d want=0", n_bcr + n_ecr + n_cal + n_err);
      end
      total++;
      if (n_busy !== 5) begin bad++; $display("FAIL lv1_busy got=%0d want=5", n_busy); end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      send(64'({9'b10110_0010, 5'b11101}), 14);
      idle(10);
      total++;
      if (n_ecr !== 1 || ecr_cyc !== t0 + 9) begin
         bad++; $display("FAIL b2b_ecr got=%0d@%0d want=1@%0d", n_ecr, ecr_cyc, t0 + 9);
      end
      total++;
      if (n_lv1 !== 1 || lv1_cyc !== t0 + 14) begin
         bad++; $display("FAIL b2b_lv1 got=%0d@%0d want=1@%0d", n_lv1, lv1_cyc, t0 + 14);
      end
      total++;
      if (n_err !== 0) begin bad++; $display("FAIL b2b_err got=%0d want=0", n_err); end
      clear_counts();
      send(64'({9'b10110_0001, 9'b10110_0100, 9'b10110_0011}), 27);
      idle(10);
      total++;
      if (n_bcr !== 1 || n_cal !== 1 || n_err !== 1) begin
         bad++; $display("FAIL fast_bcr_cal_err got=%0d/%0d/%0d want=1/1/1", n_bcr, n_cal, n_err);
      end
   endtask

   task automatic test_registers();
      clear_counts();
      send(64'({slow(F3_WR_REG, 4'b0000, 6'd27), 16'h8000}), 39);
      idle(6);
      total++;
      if (n_wr !== 1 || wr_cyc !== t0 + 39) begin
         bad++; $display("FAIL wrreg_strobe got=%0d@%0d want=1@%0d", n_wr, wr_cyc, t0 + 39);
      end
      total++;
      if (rec_addr !== 27 || rec_data !== 32'h8000) begin
         bad++; $display("FAIL wrreg_payload got=%0d/%h want=27/8000", rec_addr, rec_data);
      end
      clear_counts();
      send(64'({slow(F3_WR_REG, 4'b0101, 6'd27), 16'h8000}), 39);
      idle(6);
      total++;
      if (n_wr !== 0 || n_err !== 0) begin
         bad++; $display("FAIL wrreg_other_chip got=%0d/%0d want=0/0", n_wr, n_err);
      end
      clear_counts();
      send(64'({slow(F3_WR_REG, 4'b1010, 6'd12), 16'h1234}), 39);
      idle(6);
      total++;
      if (n_wr !== 1 || rec_addr !== 12 || rec_data !== 32'h1234) begin
         bad++; $display("FAIL wrreg_broadcast got=%0d/%0d/%h want=1/12/1234", n_wr, rec_addr, rec_data);
      end
      clear_counts();
      send(64'({slow(F3_RD_REG, 4'b0000, 6'd5), slow(F3_RD_REG, 4'b0001, 6'd9)}), 46);
      idle(6);
      total++;
      if (n_rd !== 1 || rec_addr !== 5) begin
         bad++; $display("FAIL rdreg got=%0d/%0d want=1/5", n_rd, rec_addr);
      end
      total++;
      if (bus.REG_ADDR !== 6'd5) begin bad++; $display("FAIL rdreg_addr_hold got=%0d want=5", bus.REG_ADDR); end
   endtask

   task automatic test_run_mode();
      clear_counts();
      send(64'(slow(F3_RUNMODE, 4'b0000, RUNMODE_RUN)), 23);
      idle(3);
      total++;
      if (bus.RUN_MODE !== 1'b1) begin bad++; $display("FAIL runmode_set got=%b want=1", bus.RUN_MODE); end
      send(64'(slow(F3_RUNMODE, 4'b0000, RUNMODE_CONF)), 23);
      idle(3);
      total++;
      if (bus.RUN_MODE !== 1'b0) begin bad++; $display("FAIL runmode_clr got=%b want=0", bus.RUN_MODE); end
      send(64'(slow(F3_RUNMODE, 4'b0000, RUNMODE_RUN)), 23);
      send(64'(slow(F3_RUNMODE, 4'b0000, 6'b101010)), 23);
      idle(3);
      total++;
      if (n_err !== 1 || bus.RUN_MODE !== 1'b1) begin
         bad++; $display("FAIL runmode_bad got=%0d/%b want=1/1", n_err, bus.RUN_MODE);
      end
      clear_counts();
      send(64'(slow(F3_GRST, 4'b1000, 6'd0)), 23);
      idle(3);
      total++;
      if (n_grst !== 1) begin bad++; $display("FAIL grst got=%0d want=1", n_grst); end
   endtask

   task automatic test_gpulse();
      clear_counts();
      send(64'(slow(F3_GPULSE, 4'b0000, 6'd10)), 23);
      idle(20);
      total++;
      if (n_gp !== 10 || gp_first !== t0 + 23) begin
         bad++; $display("FAIL gpulse_w10 got=%0d@%0d want=10@%0d", n_gp, gp_first, t0 + 23);
      end
      clear_counts();
      send(64'(slow(F3_GPULSE, 4'b0000, 6'd0)), 23);
      idle(10);
      total++;
      if (n_gp !== 1) begin bad++; $display("FAIL gpulse_w0 got=%0d want=1", n_gp); end
      clear_counts();
      send(64'(slow(F3_GPULSE, 4'b0000, 6'd20)), 23);
      send(64'(5'b11101), 5);
      idle(30);
      total++;
      if (n_gp !== 20 || n_lv1 !== 1 || n_err !== 0) begin
         bad++; $display("FAIL gpulse_lv1 got=%0d/%0d/%0d want=20/1/0", n_gp, n_lv1, n_err);
      end
   endtask

   task automatic test_wr_fe();
      clear_counts();
      send(64'(slow(F3_WR_FE, 4'b0000, 6'd0)), 23);
      for (int i = 0; i < 672; i++) begin
         @(negedge CMD_CLK);
         bus.CMD_DATA = ((i % 2) == 0);
      end
      idle(6);
      total++;
      if (n_fev !== 672 || fe_bad !== 0) begin
         bad++; $display("FAIL wrfe_payload got=%0d/%0d want=672/0", n_fev, fe_bad);
      end
      total++;
      if (n_fedone !== 1 || fe_done_at !== 672) begin
         bad++; $display("FAIL wrfe_done got=%0d@%0d want=1@672", n_fedone, fe_done_at);
      end
      total++;
      if (fe_first !== t0 + 24) begin bad++; $display("FAIL wrfe_first got=%0d want=%0d", fe_first, t0 + 24); end
      send(64'(slow(F3_RUNMODE, 4'b0000, RUNMODE_RUN)), 23);
      idle(3);
      clear_counts();
      send(64'(slow(F3_WR_FE, 4'b0000, 6'd0)), 23);
      for (int i = 0; i < 300; i++) begin
         @(negedge CMD_CLK);
         bus.CMD_DATA = ((i % 2) == 0);
      end
      @(negedge CMD_CLK);
      RST = 1'b1;
      bus.CMD_DATA = 1'b0;
      @(negedge CMD_CLK);
      total++;
      if (all_outs() !== 36'd0) begin bad++; $display("FAIL rst_mid_fe got=%h want=0", all_outs()); end
      RST = 1'b0;
      idle(3);
      clear_counts();
      send(64'(5'b11101), 5);
      idle(8);
      total++;
      if (n_lv1 !== 1 || n_fedone !== 0 || n_fev !== 0) begin
         bad++; $display("FAIL rst_then_lv1 got=%0d/%0d/%0d want=1/0/0", n_lv1, n_fedone, n_fev);
      end
   endtask

   task automatic test_bad_header();
      clear_counts();
      send(64'({5'b11000, 5'b11101}), 10);
      idle(8);
      total++;
      if (n_err !== 1 || err_cyc !== t0 + 5) begin
         bad++; $display("FAIL badhdr_err got=%0d@%0d want=1@%0d", n_err, err_cyc, t0 + 5);
      end
      total++;
      if (n_lv1 !== 1 || lv1_cyc !== t0 + 10) begin
         bad++; $display("FAIL badhdr_lv1 got=%0d@%0d want=1@%0d", n_lv1, lv1_cyc, t0 + 10);
      end
   endtask

   initial begin
      bus.CMD_DATA = 1'b0;
      clear_counts();
      test_reset();
      test_lv1();
      test_back_to_back();
      test_registers();
      test_run_mode();
      test_gpulse();
      test_wr_fe();
      test_bad_header();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
